mult2_product_accumulator: RTL and testbench

- Downstream consumer of the 2-bit multiplier stage.
- Takes the 4-bit product {Co, S[2], S[1], S[0]} through a valid/ready handshake.
- Sums COUNT consecutive products into an ACC_W-bit accumulator.
- Presents the finished sum on an output valid/ready handshake, then starts the next block.

---
 rtl/mult2_product_accumulator_if.sv | 21 ++
 rtl/mult2_product_accumulator.sv | 53 +++++
 tb/tb_mult2_product_accumulator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mult2_product_accumulator_if.sv
// mult2_product_accumulator_if: product-in / sum-out handshake bundle (master drives products, slave is the accumulator)
interface mult2_product_accumulator_if #(parameter int ACC_W = 8);
  logic clear;
  logic in_valid;
  logic in_ready;
  logic [2:0] prod_s;
  logic prod_co;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] acc_out;
  logic ovf;
  logic busy;
  modport master(
    output clear, in_valid, prod_s, prod_co, out_ready,
    input in_ready, out_valid, acc_out, ovf, busy
  );
  modport slave(
    input clear, in_valid, prod_s, prod_co, out_ready,
    output in_ready, out_valid, acc_out, ovf, busy
  );
endinterface

// File: rtl/mult2_product_accumulator.sv
// mult2_product_accumulator: sums COUNT 4-bit products {co,s} into ACC_W bits, hands sum out (clk, rst, bus slave; MULT2_ACC_SATURATE_EN clamps instead of wrapping)
module mult2_product_accumulator #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input logic clk,
  input logic rst,
  mult2_product_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, DONE} state_t;
  localparam int CW = $clog2(COUNT + 1);
  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [ACC_W-1:0] acc, acc_n, add_res;
  logic [ACC_W:0] sum;
  logic ovf, ovf_n, busy, busy_n, accept, rel, last;
  always_comb begin
    accept = bus.in_valid & (state == ACCUM);
    rel = (state == DONE) & bus.out_ready;
    last = count == CW'(COUNT - 1);
    sum = {1'b0, acc} + (ACC_W + 1)'({bus.prod_co, bus.prod_s});
`ifdef MULT2_ACC_SATURATE_EN
    add_res = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    add_res = sum[ACC_W-1:0];
`endif
    state_n = (accept & last) ? DONE : rel ? ACCUM : state;
    count_n = accept ? count + CW'(1) : rel ? '0 : count;
    acc_n = accept ? add_res : rel ? '0 : acc;
    ovf_n = accept ? (ovf | sum[ACC_W]) : rel ? 1'b0 : ovf;
    busy_n = (count_n != '0) | (state_n == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst | bus.clear) begin
      state <= ACCUM;
      count <= '0;
      acc <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      acc <= acc_n;
      ovf <= ovf_n;
      busy <= busy_n;
    end
  end
  assign bus.in_ready = state == ACCUM;
  assign bus.out_valid = state == DONE;
  assign bus.acc_out = acc;
  assign bus.ovf = ovf;
  assign bus.busy = busy;
endmodule

// File: tb/tb_mult2_product_accumulator.sv
// tb_mult2_product_accumulator: directed checks of three accumulator configs against a true-sum reference model
module tb_mult2_product_accumulator;
  localparam int W[3] = '{8, 5, 8};
  localparam int C[3] = '{4, 4, 1};
  logic clk = 1'b0;
  logic [2:0] rst, clr, iv, ordy;
  logic [3:0] pr [3];
  logic [2:0] ir, ov, of, bz;
  logic [7:0] ac [3];
  int m_sum [3] = '{0, 0, 0};
  int m_n [3] = '{0, 0, 0};
  bit m_done [3] = '{0, 0, 0};
  bit chk = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    mult2_product_accumulator_if #(.ACC_W(W[g])) b();
    mult2_product_accumulator #(.ACC_W(W[g]), .COUNT(C[g])) dut(.clk(clk), .rst(rst[g]), .bus(b));
    assign b.clear = clr[g];
    assign b.in_valid = iv[g];
    assign b.prod_co = pr[g][3];
    assign b.prod_s = pr[g][2:0];
    assign b.out_ready = ordy[g];
    assign ir[g] = b.in_ready;
    assign ov[g] = b.out_valid;
    assign of[g] = b.ovf;
    assign bz[g] = b.busy;
    assign ac[g] = 8'(b.acc_out);
  end
  function automatic int maxv(int i);
    return (1 << W[i]) - 1;
  endfunction
  function automatic int exp_acc(int i);
`ifdef MULT2_ACC_SATURATE_EN
    return m_sum[i] > maxv(i) ? maxv(i) : m_sum[i];
`else
    return m_sum[i] % (maxv(i) + 1);
`endif
  endfunction
  task automatic cmp(string nm, int i, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", nm, i, act, exp);
    end
  endtask
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (rst[i] | clr[i]) begin
        m_sum[i] <= 0;
        m_n[i] <= 0;
        m_done[i] <= 1'b0;
      end else if (m_done[i]) begin
        if (ordy[i]) begin
          m_sum[i] <= 0;
          m_n[i] <= 0;
          m_done[i] <= 1'b0;
        end
      end else if (iv[i]) begin
        m_sum[i] <= m_sum[i] + int'(pr[i]);
        m_n[i] <= m_n[i] + 1;
        m_done[i] <= (m_n[i] + 1) == C[i];
      end
  always @(negedge clk)
    if (chk)
      for (int i = 0; i < 3; i++) begin
        cmp("in_ready", i, int'(ir[i]), int'(!m_done[i]));
        cmp("out_valid", i, int'(ov[i]), int'(m_done[i]));
        cmp("acc_out", i, int'(ac[i]), exp_acc(i));
        cmp("ovf", i, int'(of[i]), int'(m_sum[i] > maxv(i)));
        cmp("busy", i, int'(bz[i]), int'(m_n[i] != 0 || m_done[i]));
      end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(int i, bit v, int p);
    iv[i] = v;
    pr[i] = 4'(p);
    tick();
  endtask
  initial begin
    int bub [4];
    rst = 3'b111;
    clr = '0;
    iv = '0;
    ordy = 3'b111;
    for (int i = 0; i < 3; i++) pr[i] = '0;
    tick();
    tick();
    rst = '0;
    chk = 1'b1;
    cmp("rst_acc", 0, int'(ac[0]), 0);
    cmp("rst_in_ready", 0, int'(ir[0]), 1);
    put(0, 1, 9);
    cmp("run9", 0, int'(ac[0]), 9);
    put(0, 1, 6);
    cmp("run15", 0, int'(ac[0]), 15);
    put(0, 1, 4);
    cmp("run19", 0, int'(ac[0]), 19);
    put(0, 1, 1);
    cmp("nom_sum", 0, int'(ac[0]), 'h14);
    cmp("nom_valid", 0, int'(ov[0]), 1);
    cmp("nom_ovf", 0, int'(of[0]), 0);
    cmp("nom_in_ready", 0, int'(ir[0]), 0);
    put(0, 0, 0);
    cmp("nom_after_acc", 0, int'(ac[0]), 0);
    cmp("nom_after_ready", 0, int'(ir[0]), 1);
    put(0, 1, 9);
    put(0, 1, 6);
    put(0, 1, 4);
    ordy[0] = 1'b0;
    put(0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      put(0, 1, 5);
      cmp("bp_hold_acc", 0, int'(ac[0]), 'h14);
      cmp("bp_hold_ready", 0, int'(ir[0]), 0);
    end
    ordy[0] = 1'b1;
    put(0, 1, 5);
    cmp("bp_release_acc", 0, int'(ac[0]), 0);
    put(0, 1, 5);
    cmp("bp_next_block", 0, int'(ac[0]), 5);
    clr[0] = 1'b1;
    put(0, 0, 0);
    clr[0] = 1'b0;
    cmp("clr_busy", 0, int'(bz[0]), 0);
    bub = '{3, 2, 1, 0};
    for (int k = 0; k < 4; k++) begin
      put(0, 1, bub[k]);
      cmp("bub_busy", 0, int'(bz[0]), 1);
      if (k < 3) put(0, 0, 0);
    end
    cmp("bub_sum", 0, int'(ac[0]), 6);
    cmp("bub_valid", 0, int'(ov[0]), 1);
    put(0, 0, 0);
    for (int a = 0; a < 2; a++) begin
      put(0, 1, 9);
      put(0, 1, 9);
      if (a == 0) clr[0] = 1'b1;
      else rst[0] = 1'b1;
      put(0, 1, 4);
      clr[0] = 1'b0;
      rst[0] = 1'b0;
      cmp("abort_acc", 0, int'(ac[0]), 0);
      cmp("abort_busy", 0, int'(bz[0]), 0);
      cmp("abort_valid", 0, int'(ov[0]), 0);
    end
    for (int k = 0; k < 4; k++) put(0, 1, 1);
    cmp("post_abort_sum", 0, int'(ac[0]), 4);
    cmp("post_abort_valid", 0, int'(ov[0]), 1);
    put(0, 0, 0);
    for (int k = 0; k < 4; k++) put(1, 1, 9);
`ifdef MULT2_ACC_SATURATE_EN
    cmp("ovf_sum", 1, int'(ac[1]), 31);
`else
    cmp("ovf_sum", 1, int'(ac[1]), 4);
`endif
    cmp("ovf_flag", 1, int'(of[1]), 1);
    put(1, 0, 0);
    cmp("ovf_cleared", 1, int'(of[1]), 0);
    for (int k = 0; k < 6; k++) begin
      put(2, 1, 7);
      cmp("c1_valid", 2, int'(ov[2]), int'(k % 2 == 0));
      cmp("c1_acc", 2, int'(ac[2]), (k % 2 == 0) ? 7 : 0);
      cmp("c1_ready", 2, int'(ir[2]), int'(k % 2 == 1));
    end
    put(2, 0, 0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
